oled_spi_capture: RTL

Receive-side counterpart of the PmodOLED write path: an SPI responder that decodes the 4-wire OLED stream (CS, SCLK, SDO, DC) the display driver emits. It parses page and column commands, writes data bytes into a 4-page × 128-column frame memory, and exposes a read port and per-byte strobes. It sits on the OLED pins in loopback or bench builds, so the rendered screen can be checked without a panel.

---
 rtl/oled_pkg.sv | 17 +
 rtl/spi_byte_rx.sv | 84 ++++++++
 rtl/oled_spi_capture.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED SPI capture block: frame geometry,
// SSD1306-style page/column command encodings and the parser state type.
package oled_pkg;

   localparam int OLED_PAGES = 4;
   localparam int OLED_COLS  = 128;

   localparam logic [7:0] CMD_SET_PAGE = 8'h22;
   localparam logic [3:0] CMD_COL_LO   = 4'h0;
   localparam logic [4:0] CMD_COL_HI   = 5'b00010;

   typedef enum logic {
      CMD,
      PAGE_ARG
   } parse_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI responder front end: synchronizes CS/SCLK/SDI/DC, detects SCLK rising
// edges and assembles MSB-first bytes, emitting one strobe per completed byte.
module spi_byte_rx #(
   parameter int OVERSAMPLE_MIN = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cs_i,
   input  logic       sclk_i,
   input  logic       sdi_i,
   input  logic       dc_i,
   output logic       byte_vld_o,
   output logic [7:0] byte_o,
   output logic       byte_dc_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;
   logic       sclkPrev_q;
   logic [2:0] bitCnt_q;
   logic [6:0] shift_q;
   logic [3:0] halfCnt_q;
   logic       byteVld_q;
   logic [7:0] byte_q;
   logic       byteDc_q;

   logic csS;
   logic sclkS;
   logic sdiS;
   logic dcS;
   logic sclkRise;

   assign {csS, sclkS, sdiS, dcS} = sync_q;
   assign sclkRise = sclkS & ~sclkPrev_q;

   // Synchronizer stages reset to the idle bus (CS high, SCLK high) so that
   // leaving reset never looks like a select or a clock edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q     <= 4'b1100;
         sync_q     <= 4'b1100;
         sclkPrev_q <= 1'b1;
         bitCnt_q   <= 3'd0;
         shift_q    <= 7'd0;
         byteVld_q  <= 1'b0;
         byte_q     <= 8'h00;
         byteDc_q   <= 1'b0;
      end else begin
         meta_q     <= {cs_i, sclk_i, sdi_i, dc_i};
         sync_q     <= meta_q;
         sclkPrev_q <= sclkS;
         byteVld_q  <= 1'b0;
         if (csS) begin
            bitCnt_q <= 3'd0;
         end else if (sclkRise) begin
            shift_q  <= {shift_q[5:0], sdiS};
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
               byte_q    <= {shift_q, sdiS};
               byteDc_q  <= dcS;
               byteVld_q <= 1'b1;
            end
         end
      end
   end

   // Cycles since the last synchronized SCLK transition; guards the minimum
   // oversampling ratio the edge detector relies on.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         halfCnt_q <= '1;
      end else if (sclkS != sclkPrev_q) begin
         assert (halfCnt_q >= 4'(OVERSAMPLE_MIN));
         halfCnt_q <= 4'd1;
      end else if (halfCnt_q != '1) begin
         halfCnt_q <= halfCnt_q + 4'd1;
      end
   end

   assign byte_vld_o = byteVld_q;
   assign byte_o     = byte_q;
   assign byte_dc_o  = byteDc_q;

endmodule

// File: rtl/oled_spi_capture.sv
// OLED stream capture: parses page/column commands and stores data bytes in a
// 4x128 frame memory. Optional FRAME_DONE pulse under OLED_CAP_FRAME_DONE_EN.
module oled_spi_capture
   import oled_pkg::*;
#(
   parameter int OVERSAMPLE_MIN = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cs_i,
   input  logic       sclk_i,
   input  logic       sdi_i,
   input  logic       dc_i,
   input  logic [1:0] rd_page_i,
   input  logic [6:0] rd_col_i,
   output logic [7:0] rd_data_o,
   output logic       byte_vld_o,
   output logic [7:0] byte_o,
   output logic       byte_dc_o,
   output logic       cmd_err_o,
   output logic [1:0] cur_page_o,
   output logic [6:0] cur_col_o,
   output logic       frame_done_o
);

   logic       rxVld;
   logic [7:0] rxByte;
   logic       rxDc;

   spi_byte_rx #(
      .OVERSAMPLE_MIN(OVERSAMPLE_MIN)
   ) u_rx (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cs_i      (cs_i),
      .sclk_i    (sclk_i),
      .sdi_i     (sdi_i),
      .dc_i      (dc_i),
      .byte_vld_o(rxVld),
      .byte_o    (rxByte),
      .byte_dc_o (rxDc)
   );

   parse_state_e state_q, state_d;
   logic errD, dataD, pageD, colLoD, colHiD;

   logic       byteVld_q;
   logic [7:0] byte_q;
   logic       byteDc_q;
   logic       cmdErr_q;
   logic       dataWr_q;
   logic       pageWr_q;
   logic       colLoWr_q;
   logic       colHiWr_q;
   logic [1:0] curPage_q;
   logic [6:0] curCol_q;
   logic [7:0] rdData_q;
   logic [7:0] mem_q [OLED_PAGES*OLED_COLS];

   // A data byte arriving while a page argument is expected aborts the
   // command and is still written as pixel data.
   always_comb begin
      state_d = state_q;
      errD    = 1'b0;
      dataD   = 1'b0;
      pageD   = 1'b0;
      colLoD  = 1'b0;
      colHiD  = 1'b0;
      if (rxDc) begin
         dataD = 1'b1;
         if (state_q == PAGE_ARG) begin
            errD    = 1'b1;
            state_d = CMD;
         end
      end else if (state_q == PAGE_ARG) begin
         pageD   = 1'b1;
         state_d = CMD;
      end else if (rxByte == CMD_SET_PAGE) begin
         state_d = PAGE_ARG;
      end else if (rxByte[7:4] == CMD_COL_LO) begin
         colLoD = 1'b1;
      end else if (rxByte[7:3] == CMD_COL_HI) begin
         colHiD = 1'b1;
      end else begin
         errD = 1'b1;
      end
   end

   // Stage 1 registers the byte, strobes and pending actions; stage 2 applies
   // the address updates one cycle later, alongside the memory write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= CMD;
         byteVld_q <= 1'b0;
         byte_q    <= 8'h00;
         byteDc_q  <= 1'b0;
         cmdErr_q  <= 1'b0;
         dataWr_q  <= 1'b0;
         pageWr_q  <= 1'b0;
         colLoWr_q <= 1'b0;
         colHiWr_q <= 1'b0;
         curPage_q <= 2'd0;
         curCol_q  <= 7'd0;
      end else begin
         byteVld_q <= rxVld;
         cmdErr_q  <= rxVld & errD;
         dataWr_q  <= rxVld & dataD;
         pageWr_q  <= rxVld & pageD;
         colLoWr_q <= rxVld & colLoD;
         colHiWr_q <= rxVld & colHiD;
         if (rxVld) begin
            state_q  <= state_d;
            byte_q   <= rxByte;
            byteDc_q <= rxDc;
         end
         if (dataWr_q) begin
            curCol_q <= curCol_q + 7'd1;
         end else if (colLoWr_q) begin
            curCol_q[3:0] <= byte_q[3:0];
         end else if (colHiWr_q) begin
            curCol_q[6:4] <= byte_q[2:0];
         end
         if (pageWr_q) begin
            curPage_q <= byte_q[1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (dataWr_q) begin
         mem_q[{curPage_q, curCol_q}] <= byte_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdData_q <= 8'h00;
      end else begin
         rdData_q <= mem_q[{rd_page_i, rd_col_i}];
      end
   end

`ifdef OLED_CAP_FRAME_DONE_EN
   logic frameDone_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frameDone_q <= 1'b0;
      end else begin
         frameDone_q <= rxVld & dataD
                        & (curPage_q == 2'(OLED_PAGES - 1))
                        & (curCol_q == 7'(OLED_COLS - 1));
      end
   end

   assign frame_done_o = frameDone_q;
`else
   assign frame_done_o = 1'b0;
`endif

   assign rd_data_o  = rdData_q;
   assign byte_vld_o = byteVld_q;
   assign byte_o     = byte_q;
   assign byte_dc_o  = byteDc_q;
   assign cmd_err_o  = cmdErr_q;
   assign cur_page_o = curPage_q;
   assign cur_col_o  = curCol_q;

endmodule
